// File: rtl/sll_mc.sv
// Multi-cycle logical left shifter: shifts a latched operand by at most STEP
// bit positions per clock and returns the zero-filled result over valid/ready.
module sll_mc #(
    parameter int WIDTH = 32,
    parameter int SA_W  = 5,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SA_W-1:0]  in_sa,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    input  logic             flush
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [SA_W-1:0] STEP_C = SA_W'(STEP);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [SA_W-1:0]  rem;
    logic [SA_W-1:0]  step;
    logic [SA_W-1:0]  rem_nxt;

    always_comb begin
        step    = (rem < STEP_C) ? rem : STEP_C;
        rem_nxt = rem - step;
    end

    assign in_ready  = (state == IDLE) && !flush;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = acc;

    // flush outranks both handshakes; a result taken together with flush is simply dropped
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            acc   <= '0;
            rem   <= '0;
        end else if (flush) begin
            state <= IDLE;
            acc   <= '0;
            rem   <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    acc   <= in_data;
                    rem   <= in_sa;
                    state <= (in_sa == '0) ? DONE : SHIFT;
                end
                SHIFT: begin
                    acc <= acc << step;
                    rem <= rem_nxt;
                    if (rem_nxt == '0) state <= DONE;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sll_mc.sv
// Directed bench for sll_mc: instance 0 uses STEP=4, instance 1 uses STEP=1.
module tb_sll_mc;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [31:0] in_data   [2];
    logic [4:0]  in_sa     [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] out_data  [2];
    logic        busy      [2];
    logic        flush     [2];

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    sll_mc #(.WIDTH(32), .SA_W(5), .STEP(4)) u_s4 (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_sa(in_sa[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .busy(busy[0]), .flush(flush[0])
    );

    sll_mc #(.WIDTH(32), .SA_W(5), .STEP(1)) u_s1 (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_sa(in_sa[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .busy(busy[1]), .flush(flush[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request: checks busy/in_ready during SHIFT, latency, result, stability
    // under `hold` cycles of backpressure, and return to IDLE after the handshake.
    task automatic do_req(input int d, input logic [31:0] data, input logic [4:0] sa, input int hold);
        int k, lat, stp;
        logic [31:0] exp;
        exp = data << sa;
        stp = (d == 0) ? 4 : 1;
        lat = 1 + (int'(sa) + stp - 1) / stp;
        k = 0;
        while (!in_ready[d] && k < 50) begin tick(); k++; end
        chk("accept_ready", {31'b0, in_ready[d]}, 32'd1);
        in_valid[d] = 1'b1; in_data[d] = data; in_sa[d] = sa;
        tick();
        in_valid[d] = 1'b0; in_data[d] = $urandom; in_sa[d] = 5'($urandom);
        k = 1;
        while (!out_valid[d] && k < 100) begin
            chk("shift_busy", {31'b0, busy[d]}, 32'd1);
            chk("shift_ready", {31'b0, in_ready[d]}, 32'd0);
            tick();
            k++;
        end
        chk("latency", k, lat);
        chk("result", out_data[d], exp);
        repeat (hold) begin
            chk("bp_ready", {31'b0, in_ready[d]}, 32'd0);
            tick();
            chk("bp_valid", {31'b0, out_valid[d]}, 32'd1);
            chk("bp_data", out_data[d], exp);
        end
        chk("done_busy", {31'b0, busy[d]}, 32'd1);
        out_ready[d] = 1'b1;
        tick();
        out_ready[d] = 1'b0;
        chk("idle_busy", {31'b0, busy[d]}, 32'd0);
        chk("idle_valid", {31'b0, out_valid[d]}, 32'd0);
        chk("idle_ready", {31'b0, in_ready[d]}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; in_data[i] = '0; in_sa[i] = '0;
            out_ready[i] = 1'b0; flush[i] = 1'b0;
        end
        #12;
        chk("rst_valid", {31'b0, out_valid[0]}, 32'd0);
        chk("rst_data", out_data[0], 32'd0);
        chk("rst_busy", {31'b0, busy[0]}, 32'd0);
        chk("rst_ready", {31'b0, in_ready[0]}, 32'd1);
        tick();
        resetn = 1'b1;

        // zero shift, then max shift, then a short shift
        do_req(0, 32'h1234_5678, 5'd0, 0);
        do_req(0, 32'hFFFF_FFFF, 5'd31, 0);
        do_req(0, 32'h0000_0001, 5'd5, 0);
        do_req(1, 32'hFFFF_FFFF, 5'd31, 0);

        // backpressure: out_ready low for 10 cycles
        do_req(0, 32'h0000_00AB, 5'd8, 10);

        // flush mid-SHIFT
        in_valid[0] = 1'b1; in_data[0] = 32'hDEAD_BEEF; in_sa[0] = 5'd20;
        tick();                                   // C1
        in_valid[0] = 1'b0;
        tick();                                   // C2
        flush[0] = 1'b1;
        chk("flush_ready", {31'b0, in_ready[0]}, 32'd0);
        tick();                                   // C3
        flush[0] = 1'b0;
        chk("flush_busy", {31'b0, busy[0]}, 32'd0);
        chk("flush_data", out_data[0], 32'd0);
        repeat (6) begin
            chk("flush_novalid", {31'b0, out_valid[0]}, 32'd0);
            tick();
        end
        // request presented together with flush is not taken
        flush[0] = 1'b1; in_valid[0] = 1'b1; in_data[0] = 32'h5; in_sa[0] = 5'd3;
        #1;
        chk("flushreq_ready", {31'b0, in_ready[0]}, 32'd0);
        tick();
        flush[0] = 1'b0; in_valid[0] = 1'b0;
        chk("flushreq_busy", {31'b0, busy[0]}, 32'd0);
        do_req(0, 32'h0000_0003, 5'd1, 0);

        // reset while holding a result in DONE
        in_valid[0] = 1'b1; in_data[0] = 32'h0000_00AB; in_sa[0] = 5'd8;
        tick();
        in_valid[0] = 1'b0;
        tick();
        tick();
        chk("pre_rst_valid", {31'b0, out_valid[0]}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid[0]}, 32'd0);
        chk("mid_rst_data", out_data[0], 32'd0);
        chk("mid_rst_busy", {31'b0, busy[0]}, 32'd0);
        tick();
        resetn = 1'b1;
        do_req(0, 32'h0000_000F, 5'd4, 0);

        // sweep every shift amount on both step sizes with random backpressure
        for (int d = 0; d < 2; d++)
            for (int s = 0; s < 32; s++)
                do_req(d, $urandom, 5'(s), $urandom_range(0, 2));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
